// File: rtl/shift_reg_seq_if.sv
// shift_reg_seq bus: command inputs and register status.
// master drives commands, slave is the register.
interface shift_reg_seq_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin_l;
    logic             sin_r;
    logic             start;
    logic [CNT_W-1:0] n;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, d, sin_l, sin_r, start, n,
        input  q, sout_l, sout_r, busy, done
    );

    modport slave (
        input  en, mode, d, sin_l, sin_r, start, n,
        output q, sout_l, sout_r, busy, done
    );
endinterface

// File: rtl/shift_reg_seq.sv
// WIDTH-bit universal register with hold/load/shift/rotate/clear
// and a sequencer that repeats a shift or rotate n times.
module shift_reg_seq #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 4
) (
    input logic            clk,
    input logic            rst,
    shift_reg_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_r;
    logic             busy_r;
    logic             done_r;
    logic             seq_op;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] v,
        input logic [WIDTH-1:0] dv,
        input logic             sl,
        input logic             sr
    );
        logic [WIDTH-1:0] r;
        r = v;
        unique case (op)
            3'b000: r = v;
            3'b001: r = dv;
            3'b010: r = {v[WIDTH-2:0], sr};
            3'b011: r = {sl, v[WIDTH-1:1]};
            3'b100: r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'b101: r = {v[0], v[WIDTH-1:1]};
            3'b110: r = {v[WIDTH-1], v[WIDTH-1:1]};
            3'b111: r = '0;
        endcase
        return r;
    endfunction

    // Only the shift/rotate family can be sequenced.
    always_comb begin
        seq_op = 1'b0;
        unique case (1'b1)
            (bus.mode == 3'b000): seq_op = 1'b0;
            (bus.mode == 3'b001): seq_op = 1'b0;
            (bus.mode == 3'b111): seq_op = 1'b0;
            default:              seq_op = 1'b1;
        endcase
    end

    // Sequencer FSM and register update with registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q_r    <= RESET_VAL;
            cnt    <= '0;
            mode_r <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start && seq_op) begin
                        if (bus.n != '0) begin
                            mode_r <= bus.mode;
                            cnt    <= bus.n;
                            state  <= RUN;
                            busy_r <= 1'b1;
                            done_r <= 1'b0;
                        end else begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end else begin
                        if (bus.en) begin
                            q_r <= apply_op(bus.mode, q_r, bus.d,
                                            bus.sin_l, bus.sin_r);
                        end
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.en) begin
                        q_r <= apply_op(mode_r, q_r, bus.d,
                                        bus.sin_l, bus.sin_r);
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state  <= DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q      = q_r;
    assign bus.sout_l = q_r[WIDTH-1];
    assign bus.sout_r = q_r[0];
    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
endmodule

// File: tb/tb_shift_reg_seq.sv
// Bench for shift_reg_seq: directed plan plus random commands,
// scoreboarded against a behavioural model.
module tb_shift_reg_seq;
    localparam int         W  = 8;
    localparam int         CW = 4;
    localparam logic [7:0] RV = 8'hA5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_reg_seq_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_reg_seq #(
        .WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [7:0] mq    = RV;
    int         rem   = 0;
    logic [2:0] mop   = 3'b000;
    logic       mdone = 1'b0;

    function automatic logic [7:0] op_fn(
        input logic [2:0] op, input logic [7:0] v,
        input logic [7:0] dv, input logic sl, input logic sr
    );
        int x;
        x = v;
        case (op)
            3'd0: x = v;
            3'd1: x = dv;
            3'd2: x = (v * 2 + sr) % 256;
            3'd3: x = v / 2 + (sl ? 128 : 0);
            3'd4: x = (v * 2) % 256 + v / 128;
            3'd5: x = v / 2 + (v % 2) * 128;
            3'd6: x = v / 2 + (v >= 128 ? 128 : 0);
            default: x = 0;
        endcase
        return x[7:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cyc(
        input logic r, input logic e, input logic [2:0] m,
        input logic [7:0] dd, input logic sl, input logic sr,
        input logic st, input logic [3:0] nn
    );
        exp_t x;
        @(negedge clk);
        rst       = r;
        bus.en    = e;
        bus.mode  = m;
        bus.d     = dd;
        bus.sin_l = sl;
        bus.sin_r = sr;
        bus.start = st;
        bus.n     = nn;
        if (r) begin
            mq = RV; rem = 0; mdone = 1'b0;
        end else if (rem > 0) begin
            mdone = 1'b0;
            if (e) begin
                mq = op_fn(mop, mq, dd, sl, sr);
                rem--;
                if (rem == 0) mdone = 1'b1;
            end
        end else begin
            mdone = 1'b0;
            if (st && m >= 3'd2 && m <= 3'd6) begin
                if (nn == 0) mdone = 1'b1;
                else begin rem = nn; mop = m; end
            end else if (e) begin
                mq = op_fn(m, mq, dd, sl, sr);
            end
        end
        x.q = mq; x.busy = (rem > 0); x.done = mdone;
        sb.push_back(x);
    endtask

    task automatic op(input logic [2:0] m, input logic [7:0] dd,
                      input logic sl, input logic sr);
        cyc(1'b0, 1'b1, m, dd, sl, sr, 1'b0, 4'd0);
    endtask

    task automatic seq(input logic [2:0] m, input logic [3:0] nn);
        cyc(1'b0, 1'b1, m, 8'h00, 1'b0, 1'b1, 1'b1, nn);
    endtask

    task automatic idle(input logic e, input int k);
        for (int i = 0; i < k; i++)
            cyc(1'b0, e, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
    endtask

    task automatic peek(input string nm, input logic [7:0] e);
        @(posedge clk);
        #2;
        chk(nm, bus.q, e);
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", bus.q, x.q);
                chk("busy", bus.busy, x.busy);
                chk("done", bus.done, x.done);
                chk("sout_l", bus.sout_l, x.q[7]);
                chk("sout_r", bus.sout_r, x.q[0]);
            end
        end
    end

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.mode = 3'b000; bus.d = '0;
        bus.sin_l = 1'b0; bus.sin_r = 1'b0; bus.start = 1'b0; bus.n = '0;

        cyc(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
        peek("reset_q", 8'hA5);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);

        op(3'b001, 8'h3C, 1'b0, 1'b0); peek("load", 8'h3C);
        op(3'b010, 8'h00, 1'b0, 1'b1); peek("shl", 8'h79);
        op(3'b011, 8'h00, 1'b0, 1'b0); peek("shr", 8'h3C);
        op(3'b001, 8'h81, 1'b0, 1'b0);
        op(3'b100, 8'h00, 1'b0, 1'b0); peek("rotl", 8'h03);
        op(3'b001, 8'h80, 1'b0, 1'b0);
        op(3'b110, 8'h00, 1'b0, 1'b0); peek("ashr", 8'hC0);
        op(3'b111, 8'h00, 1'b0, 1'b0); peek("clear", 8'h00);
        cyc(1'b0, 1'b0, 3'b001, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
        peek("en_low", 8'h00);

        op(3'b001, 8'h01, 1'b0, 1'b0);
        seq(3'b101, 4'd3);
        idle(1'b1, 3); peek("seq_rotr", 8'h20);
        idle(1'b1, 2);

        op(3'b001, 8'h01, 1'b0, 1'b0);
        seq(3'b101, 4'd3);
        idle(1'b1, 1);
        idle(1'b0, 2); peek("stall_hold", 8'h80);
        idle(1'b1, 2); peek("stall_end", 8'h20);
        idle(1'b1, 2);

        seq(3'b010, 4'd0);
        idle(1'b1, 2); peek("n_zero", 8'h20);

        cyc(1'b0, 1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 1'b1, 4'd3);
        peek("start_load", 8'h5A);
        idle(1'b1, 1);

        op(3'b001, 8'h01, 1'b0, 1'b0);
        seq(3'b100, 4'd2);
        idle(1'b1, 2);
        seq(3'b100, 4'd1);
        idle(1'b1, 1); peek("b2b", 8'h08);
        idle(1'b1, 1);

        op(3'b001, 8'h01, 1'b0, 1'b0);
        seq(3'b010, 4'd5);
        idle(1'b1, 2);
        cyc(1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        peek("rst_mid", 8'hA5);
        idle(1'b0, 10);

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)),
                8'($urandom),
                1'($urandom),
                1'($urandom),
                ($urandom_range(0, 5) == 0),
                4'($urandom_range(0, 15)));
        end

        @(posedge clk);
        #3;
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_reg_seq.md
Name: shift_reg_seq

Overview:
- Parametrised successor to the single-bit D flip-flop with reset: a WIDTH-bit universal register.
- Supports per-cycle operations: hold, parallel load, logical shift, rotate, arithmetic shift right and clear.
- Built-in sequencer applies a shift or rotate N times autonomously, with busy/done status.
- Used as a generic datapath register and serialiser/deserialiser building block.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits).
- CNT_W, 4, width of shift-count input n; max sequenced count 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  operation enable; in RUN it pauses the sequence when low.
- mode  in  3  operation select (encoding below).
- d  in  WIDTH  parallel load data.
- sin_l  in  1  serial input entering at MSB on shift right.
- sin_r  in  1  serial input entering at LSB on shift left.
- start  in  1  request a sequenced multi-shift using mode and n.
- n  in  CNT_W  number of shifts for a sequenced operation.
- q  out  WIDTH  register contents.
- sout_l  out  1  q[WIDTH-1], combinational from q.
- sout_r  out  1  q[0], combinational from q.
- busy  out  1  high while a sequence is in RUN.
- done  out  1  one-cycle pulse when a sequence completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: q=RESET_VAL, state=IDLE, busy=0, done=0, internal count=0.
- Reset has priority over all other inputs. Asserting rst in any state, including RUN, aborts the sequence with no done pulse.
- Mode encoding, where q' is the next value of q:
  - 000 hold: q'=q.
  - 001 load: q'=d.
  - 010 shl: q'={q[W-2:0],sin_r}.
  - 011 shr: q'={sin_l,q[W-1:1]}.
  - 100 rotl: q'={q[W-2:0],q[W-1]}.
  - 101 rotr: q'={q[0],q[W-1:1]}.
  - 110 ashr: q'={q[W-1],q[W-1:1]}.
  - 111 clear: q'=0.
- Latency: a direct operation is visible on q one cycle after the edge that samples it.
- FSM states: IDLE, RUN, DONE.
- IDLE and DONE accept commands identically, so sequences can run back to back:
  - start=1 with mode in 010..110 and n!=0: latch mode into mode_r and n into cnt, then go to RUN. q unchanged at this edge.
  - start=1 with mode in 010..110 and n=0: go to DONE; q unchanged.
  - start=1 with mode 000, 001 or 111: treated as a direct operation; start is ignored.
  - start=0 and en=1: apply mode directly, stay in/return to IDLE.
  - start=0 and en=0: hold; DONE returns to IDLE.
  - start has priority over the direct operation when both are valid.
- RUN:
  - en=1: apply mode_r once, using live sin_l/sin_r. Decrement cnt; when cnt was 1, go to DONE.
  - en=0: q and cnt hold; remain in RUN.
  - mode, d and start are ignored throughout RUN.
- Outputs by state:
  - busy=1 exactly while in RUN.
  - done=1 exactly while in DONE.
  - DONE lasts one cycle unless a new start re-enters RUN.
- Timing: start sampled at edge 0 means shifts occur at edges 1..n (no stalls), done is high in the cycle after edge n, and busy is high for n cycles.
- Count range: n may exceed WIDTH. Rotations wrap; shifts simply continue inserting the serial input.
- All arithmetic on cnt is unsigned CNT_W-bit. cnt never underflows.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst=1 for 2 cycles -> q=A5, sout_l=1, sout_r=1, busy=0, done=0.
- Direct ops, en=1, each step one cycle:
  - load d=3C -> 3C.
  - shl with sin_r=1 -> 79.
  - shr with sin_l=0 -> 3C.
  - load 81, then rotl -> 03.
  - load 80, then ashr -> C0.
  - clear -> 00.
  - en=0 with mode=001 -> q unchanged.
- Sequence: q=01, start=1, mode=rotr, n=3 -> busy high 3 cycles, q steps 80, 40, 20; done pulses one cycle; busy low; q stays 20.
- Stall: same sequence with en=0 for 2 cycles after the first shift -> q holds 80 during the stall, busy high 5 cycles total, final q=20.
- Edge starts:
  - start with n=0 -> done pulse next cycle, busy never high, q unchanged.
  - start with mode=001 and d=5A -> q=5A next cycle, no busy, no done.
  - start in DONE cycle -> new RUN begins with no idle gap.
- Reset mid-RUN: start shl n=5, assert rst after 2 shifts -> next cycle q=RESET_VAL, busy=0; no done pulse in the following 10 cycles.
